multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- op  in  6  instruction register [31:26]
- funct  in  6  instruction register [5:0]
- zero  in  1  ALU zero flag
- memready  in  1  memory access complete this cycle
- pcen  out  1  PC register write enable
- irwrite  out  1  instruction register load
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write enable
- regdst  out  1  destination register: 0=rt, 1=rd
- memtoreg  out  1  writeback source: 0=ALUOut, 1=data register
- alusrca  out  1  ALU A source: 0=PC, 1=rs
- alusrcb  out  2  ALU B source: 00=rt, 01=4, 10=ext imm, 11=ext imm<<2
- pcsrc  out  2  next-PC source: 00=ALU, 01=ALUOut, 10=jump target
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- signext  out  1  1=sign-extend imm, 0=zero-extend
- shiftl16  out  1  imm<<16
- state  out  4  current state code (debug)

Function
REQ-003 The state register SHALL be 4 bits. Codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11.
REQ-004 All outputs SHALL be combinational from state, op, funct, zero, memready and reset. Outputs not listed for a state SHALL be 0, except alucontrol, which SHALL default to 010.
REQ-005 FETCH SHALL drive alusrcb=01 and alucontrol=010. It SHALL drive irwrite=pcen=memready. It SHALL stay in FETCH while memready=0 and go to DECODE when memready=1.
REQ-006 DECODE SHALL drive alusrcb=11, signext=1 and add. Next state by op:
- 100011/101011 -> MEMADR
- 000000 -> RTEXEC
- 000100 -> BRANCH
- 001000/001001/001101/001111 -> IEXEC
- 000010 -> JUMP
- any other op -> FETCH (unsupported op; no write occurs)
REQ-007 MEMADR SHALL drive alusrca=1, alusrcb=10, signext=1 and add. It SHALL go to MEMRD for op 100011, else to MEMWR.
REQ-008 MEMRD SHALL drive iord=1 and hold until memready=1, then go to MEMWB. MEMWB SHALL drive regwrite=1 and memtoreg=1, then go to FETCH.
REQ-009 MEMWR SHALL drive iord=1 and memwrite=1 for every cycle in that state, and go to FETCH on memready=1.
REQ-010 RTEXEC SHALL drive alusrca=1 and alusrcb=00, and decode funct:
- 100000/100001 -> 010
- 100010/100011 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010/101011 -> 111
RTEXEC SHALL go to ALUWB for a listed funct. For any unlisted funct it SHALL go to FETCH, so no writeback occurs.
REQ-011 ALUWB SHALL drive regdst=1 and regwrite=1, then go to FETCH.
REQ-012 BRANCH SHALL drive alusrca=1, alusrcb=00, alucontrol=110 and pcsrc=01. It SHALL drive pcen=zero for op 000100 and pcen=~zero for op 000101. Next state is FETCH.
REQ-013 IEXEC SHALL drive alusrca=1 and alusrcb=10:
- ADDI/ADDIU: add, signext=1
- ORI: or, signext=0
- LUI: add, signext=0, shiftl16=1
IEXEC SHALL go to IWB. IWB SHALL drive regwrite=1, regdst=0 and memtoreg=0, then go to FETCH.
REQ-014 JUMP SHALL drive pcsrc=10 and pcen=1, then go to FETCH.
REQ-015 State codes 12-15 SHALL drive FETCH outputs and go to FETCH on the next edge.
REQ-016 Minimum instruction latency in cycles (memready held 1) SHALL be: LW 5, SW 4, R-type 4, I-type 4, BEQ/BNE 3, J 3. Each cycle memready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.

Reset
REQ-017 When reset=1 at a rising clk edge, state SHALL become FETCH.
REQ-018 While reset=1, pcen, irwrite, regwrite and memwrite SHALL be 0 regardless of state, including mid-instruction. A MEMWR access aborted this way SHALL drop memwrite in the same cycle reset rises.
REQ-019 After reset deasserts, the first FETCH SHALL behave per REQ-005.

Configuration
REQ-020 Macro MULTICYCLE_CTRL_BNE_EN SHALL control BNE support.
- Defined: op 000101 in DECODE goes to BRANCH, with pcen=~zero.
- Undefined: op 000101 is an unsupported op (DECODE -> FETCH), and BRANCH serves only BEQ.

Verification
REQ-021 Reset, then LW (op 100011) with memready=1 -> state 0,1,2,3,4,0; regwrite=memtoreg=1 only in state 4.
REQ-022 SW with memready=0 for 3 cycles in MEMWR -> state 5 for 4 cycles with memwrite=1 and iord=1 each cycle, then state 0.
REQ-023 BEQ with zero=1 -> pcen=1, pcsrc=01 in state 8. With zero=0 -> pcen=0. BNE with macro on: inverse result. BNE with macro off: states 0,1,0 and pcen never 1 outside FETCH.
REQ-024 LUI (001111) -> in state 9: shiftl16=1, signext=0, alucontrol=010. ORI (001101) -> in state 9: alucontrol=001, signext=0. Both then state 10 with regwrite=1.
REQ-025 Reset asserted in state 5 with memready=0 -> memwrite=0 in the same cycle, state=0 after the edge.
REQ-026 Op 111111, and R-type with funct 000000 -> no regwrite/memwrite/pcen outside FETCH; return to state 0 within 3 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
//==============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM for a multicycle MIPS-subset datapath.
//               Optional BNE support is enabled by MULTICYCLE_CTRL_BNE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       signext,
    output logic       shiftl16,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
`endif
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_ADDIU = 6'b001001;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    // Architectural write strobes before the reset override
    logic w_pcen;
    logic w_irwrite;
    logic w_memwrite;
    logic w_regwrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_pcen     = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = C_ALU_ADD;
        signext    = 1'b0;
        shiftl16   = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = memready;
                w_pcen    = memready;
                if (memready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                signext = 1'b1;
                case (op)
                    C_OP_LW, C_OP_SW:                        state_d = S_MEMADR;
                    C_OP_RTYPE:                              state_d = S_RTEXEC;
                    C_OP_BEQ:                                state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    C_OP_BNE:                                state_d = S_BRANCH;
`endif
                    C_OP_ADDI, C_OP_ADDIU, C_OP_ORI, C_OP_LUI: state_d = S_IEXEC;
                    C_OP_J:                                  state_d = S_JUMP;
                    default:                                 state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                signext = 1'b1;
                state_d = (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (memready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                if (memready) begin
                    state_d = S_FETCH;
                end
            end
            S_RTEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                state_d = S_ALUWB;
                case (funct)
                    6'b100000, 6'b100001: alucontrol = C_ALU_ADD;
                    6'b100010, 6'b100011: alucontrol = C_ALU_SUB;
                    6'b100100:            alucontrol = C_ALU_AND;
                    6'b100101:            alucontrol = C_ALU_OR;
                    6'b101010, 6'b101011: alucontrol = C_ALU_SLT;
                    default:              state_d    = S_FETCH;
                endcase
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = C_ALU_SUB;
                pcsrc      = 2'b01;
                if (op == C_OP_BEQ) begin
                    w_pcen = zero;
                end
`ifdef MULTICYCLE_CTRL_BNE_EN
                else if (op == C_OP_BNE) begin
                    w_pcen = ~zero;
                end
`endif
                state_d = S_FETCH;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    C_OP_ORI: alucontrol = C_ALU_OR;
                    C_OP_LUI: shiftl16   = 1'b1;
                    default:  signext    = 1'b1;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                w_regwrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                w_pcen  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unused codes 12-15 look like FETCH but always recover to it
                alusrcb   = 2'b01;
                w_irwrite = memready;
                w_pcen    = memready;
                state_d   = S_FETCH;
            end
        endcase
    end

    // Reset squashes every architectural write immediately, even mid-access
    assign pcen     = w_pcen     & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//==============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed plus random checks of multicycle_ctrl against an
//               instruction-path model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       signext, shiftl16;
    logic [3:0] state;

    int vectors     = 0;
    int miscompares = 0;
    int mst         = 0;   // expected state code
    int plan[$];           // states still to visit for the current instruction

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .memready  (memready),
        .pcen      (pcen),
        .irwrite   (irwrite),
        .iord      (iord),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .alucontrol(alucontrol),
        .signext   (signext),
        .shiftl16  (shiftl16),
        .state     (state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (model state %0d)", tag, obs, exp, mst);
        end
    endtask

    function automatic bit funct_known(input logic [5:0] f);
        return f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
    endfunction

    // Sequence of states an instruction walks through after FETCH
    function automatic void build_plan(input logic [5:0] o, input logic [5:0] f);
        plan.delete();
        case (o)
            6'h23:                      plan = '{1, 2, 3, 4};
            6'h2B:                      plan = '{1, 2, 5};
            6'h00:                      if (funct_known(f)) plan = '{1, 6, 7}; else plan = '{1, 6};
            6'h04:                      plan = '{1, 8};
            6'h05:                      if (BNE_EN) plan = '{1, 8}; else plan = '{1};
            6'h08, 6'h09, 6'h0D, 6'h0F: plan = '{1, 9, 10};
            6'h02:                      plan = '{1, 11};
            default:                    plan = '{1};
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input int st, input logic [5:0] o, input logic [5:0] f);
        if (st == 8) return 3'b110;
        if (st == 9 && o == 6'h0D) return 3'b001;
        if (st == 6) begin
            if (f == 6'h22 || f == 6'h23) return 3'b110;
            if (f == 6'h24) return 3'b000;
            if (f == 6'h25) return 3'b001;
            if (f == 6'h2A || f == 6'h2B) return 3'b111;
        end
        return 3'b010;
    endfunction

    task automatic check_outputs();
        bit r, taken;
        int st;
        r     = reset;
        st    = mst;
        taken = (op == 6'h04) ? zero : ((op == 6'h05 && BNE_EN) ? !zero : 1'b0);
        chk("state",      {4'd0, state},     8'(st));
        chk("pcen",       {7'd0, pcen},      8'(!r && ((st == 0 && memready) || st == 11 || (st == 8 && taken))));
        chk("irwrite",    {7'd0, irwrite},   8'(!r && st == 0 && memready));
        chk("memwrite",   {7'd0, memwrite},  8'(!r && st == 5));
        chk("regwrite",   {7'd0, regwrite},  8'(!r && (st == 4 || st == 7 || st == 10)));
        chk("iord",       {7'd0, iord},      8'(st == 3 || st == 5));
        chk("regdst",     {7'd0, regdst},    8'(st == 7));
        chk("memtoreg",   {7'd0, memtoreg},  8'(st == 4));
        chk("alusrca",    {7'd0, alusrca},   8'(st == 2 || st == 6 || st == 8 || st == 9));
        chk("alusrcb",    {6'd0, alusrcb},   8'((st == 0) ? 1 : (st == 1) ? 3 : (st == 2 || st == 9) ? 2 : 0));
        chk("pcsrc",      {6'd0, pcsrc},     8'((st == 8) ? 1 : (st == 11) ? 2 : 0));
        chk("alucontrol", {5'd0, alucontrol}, {5'd0, exp_alu(st, op, funct)});
        chk("signext",    {7'd0, signext},   8'(st == 1 || st == 2 || (st == 9 && (op == 6'h08 || op == 6'h09))));
        chk("shiftl16",   {7'd0, shiftl16},  8'(st == 9 && op == 6'h0F));
    endtask

    task automatic advance(input logic rst, input logic mr);
        if (rst) begin
            mst = 0;
            plan.delete();
        end else if ((mst == 0 || mst == 3 || mst == 5) && !mr) begin
            mst = mst;
        end else begin
            if (mst == 0) build_plan(op, funct);
            if (plan.size() > 0) mst = plan.pop_front();
            else mst = 0;
        end
    endtask

    // One clock: drive inputs, check combinational outputs, take the edge
    task automatic cycle(input logic rst, input logic mr, input logic z);
        reset    = rst;
        memready = mr;
        zero     = z;
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        advance(rst, mr);
    endtask

    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int exp_lat);
        int n;
        op    = o;
        funct = f;
        n     = 0;
        do begin
            cycle(1'b0, 1'b1, z);
            n++;
        end while (mst != 0 && n < 20);
        chk(tag, 8'(n), 8'(exp_lat));
    endtask

    initial begin
        logic [5:0] ops [11];
        logic [5:0] fns [8];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};

        reset = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; memready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mst = 0;
        plan.delete();

        // Reset held: FETCH with memready=1 must not write
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        run_instr("lat_lw",    6'h23, 6'h00, 1'b0, 5);
        run_instr("lat_sw",    6'h2B, 6'h00, 1'b0, 4);
        run_instr("lat_add",   6'h00, 6'h20, 1'b0, 4);
        run_instr("lat_slt",   6'h00, 6'h2A, 1'b0, 4);
        run_instr("lat_beq1",  6'h04, 6'h00, 1'b1, 3);
        run_instr("lat_beq0",  6'h04, 6'h00, 1'b0, 3);
        run_instr("lat_bne1",  6'h05, 6'h00, 1'b1, BNE_EN ? 3 : 2);
        run_instr("lat_bne0",  6'h05, 6'h00, 1'b0, BNE_EN ? 3 : 2);
        run_instr("lat_lui",   6'h0F, 6'h00, 1'b0, 4);
        run_instr("lat_ori",   6'h0D, 6'h00, 1'b0, 4);
        run_instr("lat_addi",  6'h08, 6'h00, 1'b0, 4);
        run_instr("lat_j",     6'h02, 6'h00, 1'b0, 3);
        run_instr("lat_badop", 6'h3F, 6'h00, 1'b0, 2);
        run_instr("lat_badfn", 6'h00, 6'h00, 1'b0, 3);

        // SW with three wait cycles in MEMWR
        op = 6'h2B;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("sw_wait_done", {4'd0, state}, 8'd0);

        // LW stalled in FETCH and MEMRD
        op = 6'h23;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("lw_wait_done", {4'd0, state}, 8'd0);

        // Reset arriving while a store is waiting in MEMWR
        op = 6'h2B;
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("rst_memwr_state", {4'd0, state}, 8'd0);
        cycle(1'b0, 1'b0, 1'b0);

        // Random instruction stream with occasional resets and wait states
        for (int i = 0; i < 1500; i++) begin
            if (mst == 0) begin
                op    = ops[$urandom_range(10, 0)];
                funct = ($urandom_range(9, 0) < 8) ? fns[$urandom_range(7, 0)] : 6'($urandom);
                if ($urandom_range(7, 0) == 0) op = 6'($urandom);
            end
            cycle(($urandom_range(49, 0) == 0), ($urandom_range(3, 0) != 0), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
